// File: rtl/sm_trace_buf.sv
// Circular PC/instruction trace buffer with arm/trigger/post-trigger capture FSM.
// Optional macro SM_TRACE_NOP_FILTER_EN: drop instr == 0 samples unless they are the trigger entry.
module sm_trace_buf #(
    parameter int DEPTH_LOG = 4,
    parameter int POST_TRIG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpuEn,
    input  logic [31:0]          pc,
    input  logic [31:0]          instr,
    input  logic                 arm,
    input  logic [31:0]          trigPc,
    input  logic                 trigForce,
    input  logic [DEPTH_LOG-1:0] rdAddr,
    input  logic                 rdSel,
    output logic [31:0]          rdData,
    output logic [DEPTH_LOG:0]   count,
    output logic [1:0]           state
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int PW    = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);
    localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [DEPTH_LOG-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG:0]     count_q, count_d;
    logic [PW-1:0]          post_q, post_d;
    logic [31:0]            rddata_q, rddata_d;
    logic [63:0]            mem_q [DEPTH];

    logic                   capture;
    logic                   trig;
    logic                   store;
    logic [DEPTH_LOG-1:0]   rd_idx;
    logic                   rd_hit;
    logic [63:0]            rd_entry;

    // arm has priority: the arm-cycle sample is never captured or used as a trigger
    assign capture = cpuEn && !arm && (state_q == S_ARMED || state_q == S_POST);
    assign trig    = capture && (state_q == S_ARMED) && ((pc == trigPc) || trigForce);

`ifdef SM_TRACE_NOP_FILTER_EN
    assign store = capture && ((instr != '0) || trig);
`else
    assign store = capture;
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        post_d  = post_q;
        if (arm) begin
            state_d = S_ARMED;
            wptr_d  = '0;
            count_d = '0;
            post_d  = '0;
        end else begin
            if (store) begin
                wptr_d = wptr_q + DEPTH_LOG'(1);
                if (count_q != FULL) begin
                    count_d = count_q + (DEPTH_LOG + 1)'(1);
                end
            end
            unique case (state_q)
                S_ARMED: begin
                    if (trig) begin
                        if (POST_TRIG == 0) begin
                            state_d = S_DONE;
                        end else begin
                            post_d  = PW'(POST_TRIG);
                            state_d = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (store) begin
                        post_d = post_q - PW'(1);
                        if (post_q == PW'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Oldest entry sits count positions behind the write pointer
    assign rd_idx   = wptr_q - count_q[DEPTH_LOG-1:0] + rdAddr;
    assign rd_hit   = {1'b0, rdAddr} < count_q;
    assign rd_entry = mem_q[rd_idx];

    always_comb begin
        rddata_d = '0;
        if (rd_hit) begin
            rddata_d = rdSel ? rd_entry[31:0] : rd_entry[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wptr_q   <= '0;
            count_q  <= '0;
            post_q   <= '0;
            rddata_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            rddata_q <= rddata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wptr_q] <= {pc, instr};
        end
    end

    assign rdData = rddata_q;
    assign count  = count_q;
    assign state  = state_q;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Scoreboard bench for sm_trace_buf: driver pushes model predictions, monitor pops and compares each cycle.
module tb_sm_trace_buf;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int PT    = 4;

    logic          clk;
    logic          rst_n;
    logic          cpuEn;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          arm;
    logic [31:0]   trigPc;
    logic          trigForce;
    logic [DL-1:0] rdAddr;
    logic          rdSel;
    logic [31:0]   rdData;
    logic [DL:0]   count;
    logic [1:0]    state;

    sm_trace_buf #(.DEPTH_LOG(DL), .POST_TRIG(PT)) dut (
        .clk(clk), .rst_n(rst_n), .cpuEn(cpuEn), .pc(pc), .instr(instr),
        .arm(arm), .trigPc(trigPc), .trigForce(trigForce),
        .rdAddr(rdAddr), .rdSel(rdSel), .rdData(rdData),
        .count(count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        int          cnt;
        int          st;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: oldest-first list of stored entries plus an abstract phase number
    logic [63:0] ent[$];
    int          m_st;
    int          m_post;

    function automatic logic [31:0] m_read(int a, bit s);
        logic [63:0] e;
        if (a < ent.size()) begin
            e = ent[a];
            return s ? e[31:0] : e[63:32];
        end
        return 32'h0;
    endfunction

    function automatic void m_update(bit en, logic [31:0] p, logic [31:0] ins, bit a, bit tf);
        bit t, nop, st_ok;
        if (a) begin
            ent.delete();
            m_st = 1;
            return;
        end
        if (!en || !(m_st == 1 || m_st == 2)) return;
        t = (m_st == 1) && ((p == trigPc) || tf);
`ifdef SM_TRACE_NOP_FILTER_EN
        nop = (ins == 32'h0);
`else
        nop = 1'b0;
`endif
        st_ok = !nop || t;
        if (st_ok) begin
            ent.push_back({p, ins});
            if (ent.size() > DEPTH) void'(ent.pop_front());
        end
        if (m_st == 1 && t) begin
            if (PT == 0) m_st = 3;
            else begin
                m_post = PT;
                m_st   = 2;
            end
        end else if (m_st == 2 && st_ok) begin
            m_post--;
            if (m_post == 0) m_st = 3;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input logic [31:0] p, input logic [31:0] ins,
                        input bit a, input bit tf, input logic [DL-1:0] ra, input bit rs);
        exp_t e;
        @(negedge clk);
        cpuEn = en; pc = p; instr = ins; arm = a; trigForce = tf; rdAddr = ra; rdSel = rs;
        e.rd = m_read(int'(ra), rs);
        m_update(en, p, ins, a, tf);
        e.cnt = ent.size();
        e.st  = m_st;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        cpuEn = 0; pc = 0; instr = 0; arm = 0; trigForce = 0; rdAddr = 0; rdSel = 0;
        #1;
        chk("reset_state", {30'b0, state}, 32'd0);
        chk("reset_count", {27'b0, count}, 32'd0);
        chk("reset_rdData", rdData, 32'd0);
        ent.delete();
        m_st   = 0;
        m_post = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every clock the DUT presents rdData/count/state for the preceding driven cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rdData !== e.rd || int'(count) != e.cnt || int'(state) != e.st) begin
                    failures++;
                    $display("FAIL sb_cycle: rdData=%0h count=%0d state=%0d expected rdData=%0h count=%0d state=%0d at %0t",
                             rdData, count, state, e.rd, e.cnt, e.st, $time);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cpuEn = 0; pc = 0; instr = 0; arm = 0; trigForce = 0; rdAddr = 0; rdSel = 0;
        trigPc = 32'hFFFF_FFFF;
        m_st = 0; m_post = 0;
        do_reset();

        // No arm: cpuEn activity must not capture anything
        for (int i = 0; i < 20; i++) step(1, i, $urandom | 32'h1, 0, (i == 7), 4'(i), 0);
        chk("idle_state", {30'b0, state}, 32'd0);
        chk("idle_count", {27'b0, count}, 32'd0);
        chk("idle_rdData", rdData, 32'd0);

        // Ten captures, no trigger
        step(1, 32'd99, 32'h1234, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, i, 32'h100 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4'd0, 0);
        chk("ten_count", {27'b0, count}, 32'd10);
        chk("ten_rd0", rdData, 32'd0);
        step(0, 0, 0, 0, 0, 4'd9, 0);
        chk("ten_rd9", rdData, 32'd9);
        step(0, 0, 0, 0, 0, 4'd9, 1);
        chk("ten_rd9_instr", rdData, 32'h109);
        chk("ten_state", {30'b0, state}, 32'd1);
        step(0, 0, 0, 0, 0, 4'd10, 0);
        chk("ten_rd_beyond", rdData, 32'd0);

        // Wrap: twenty captures into sixteen slots
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, i, 32'h200 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4'd0, 0);
        chk("wrap_count", {27'b0, count}, 32'd16);
        chk("wrap_rd0", rdData, 32'd4);
        step(0, 0, 0, 0, 0, 4'd15, 0);
        chk("wrap_rd15", rdData, 32'd19);

        // Trigger on pc 5 with four post-trigger entries
        trigPc = 32'd5;
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i <= 12; i++) step(1, i, 32'h300 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4'd9, 0);
        chk("trig_state", {30'b0, state}, 32'd3);
        chk("trig_count", {27'b0, count}, 32'd10);
        chk("trig_rd9", rdData, 32'd9);

        // Arm beats a coincident force; a later force triggers
        trigPc = 32'hFFFF_FFFF;
        step(1, 32'd50, 32'h1, 1, 1, 0, 0);
        chk("armwin_state", {30'b0, state}, 32'd1);
        chk("armwin_count", {27'b0, count}, 32'd0);
        step(0, 32'd51, 32'h1, 0, 1, 0, 0);
        chk("force_noen_state", {30'b0, state}, 32'd1);
        step(1, 32'd52, 32'h1, 0, 1, 0, 0);
        chk("force_state", {30'b0, state}, 32'd2);

`ifdef SM_TRACE_NOP_FILTER_EN
        trigPc = 32'd4;
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i <= 8; i++) step(1, i, (i == 3 || i == 4) ? 32'h0 : 32'h400 + i, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4'd3, 0);
        chk("nop_count", {27'b0, count}, 32'd8);
        chk("nop_trig_entry", rdData, 32'd4);
        chk("nop_state", {30'b0, state}, 32'd3);
`endif

        // Reset mid-capture, then a clean re-arm
        trigPc = 32'hFFFF_FFFF;
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 32'h60 + i, 32'h1, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 1, 0, 0, 0);
        chk("rearm_count", {27'b0, count}, 32'd0);
        step(1, 32'h77, 32'h5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 4'd0, 0);
        chk("rearm_rd0", rdData, 32'h77);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 40) == 0) trigPc = $urandom_range(0, 20);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 20),
                 ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
                 $urandom_range(0, 35) == 0,
                 $urandom_range(0, 40) == 0,
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        cpuEn = 0; arm = 0; trigForce = 0;
        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_trace_buf.md
SM_TRACE_BUF -- requirements
Module: sm_trace_buf

Interface
REQ-001 Parameter: DEPTH_LOG, default 4, log2 of trace entries (DEPTH = 16).
REQ-002 Parameter: POST_TRIG, default 4, entries captured after the trigger entry.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpuEn  input  1  qualifies pc/instr as a valid executed cycle (CPU clock enable).
REQ-006 pc  input  32  word PC of the executing instruction.
REQ-007 instr  input  32  instruction word at pc.
REQ-008 arm  input  1  single-cycle pulse; clears buffer and starts capture.
REQ-009 trigPc  input  32  PC value that fires the trigger.
REQ-010 trigForce  input  1  forces a trigger regardless of pc.
REQ-011 rdAddr  input  DEPTH_LOG  read index; 0 = oldest stored entry.
REQ-012 rdSel  input  1  0 = read PC field, 1 = read instr field.
REQ-013 rdData  output  32  selected field of the addressed entry.
REQ-014 count  output  DEPTH_LOG+1  number of valid entries, saturating at DEPTH.
REQ-015 state  output  2  IDLE=0, ARMED=1, POST=2, DONE=3.

Function
REQ-016 Entry = {pc, instr}; storage DEPTH x 64 bits, circular, write pointer wptr wraps DEPTH-1 -> 0.
REQ-017 Capture event = cpuEn high in state ARMED or POST; entry written at wptr, wptr increments, count increments unless already DEPTH.
REQ-018 IDLE: no capture; arm -> ARMED.
REQ-019 ARMED: capture; trigger = capture event AND (pc == trigPc OR trigForce); on trigger, triggering entry is stored, post counter loads POST_TRIG, -> POST; if POST_TRIG = 0 -> DONE directly.
REQ-020 POST: each capture event decrements post counter; capture that brings it to 0 is stored and -> DONE.
REQ-021 DONE: no capture, buffer frozen; arm -> ARMED.
REQ-022 arm in any state: wptr = 0, count = 0, -> ARMED; the sample on the arm cycle is not captured and any coincident trigger is ignored (arm wins).
REQ-023 trigForce or pc match without cpuEn has no effect.
REQ-024 Read: physical index = (wptr - count + rdAddr) mod DEPTH; rdData registered, valid one cycle after rdAddr/rdSel change.
REQ-025 rdAddr >= count returns 0.
REQ-026 Read path is independent of capture; simultaneous capture and read return the pre-write entry contents for the old wptr view.
REQ-027 After wrap, oldest entry (rdAddr 0) is the one overwritten next.

Reset
REQ-028 rst_n low asynchronously forces state = IDLE, wptr = 0, count = 0, post counter = 0, rdData = 0.
REQ-029 Storage array contents are not reset; count = 0 makes them unreadable (REQ-025).
REQ-030 Reset mid-capture discards all entries; first arm after release starts clean.

Configuration
REQ-031 Macro SM_TRACE_NOP_FILTER_EN: when defined, capture events with instr == 32'h0 are not stored and do not decrement the post counter, but can still trigger on pc match (trigger entry stored anyway); when undefined, all cpuEn cycles are captured.

Verification
REQ-032 Reset, no arm, 20 cpuEn cycles -> state 0, count 0, rdData 0.
REQ-033 arm, 10 captures pc 0..9, no trigger -> count 10, rdAddr 0 rdSel 0 -> rdData 0, rdAddr 9 -> 9, state 1.
REQ-034 arm, 20 captures pc 0..19 -> count 16, rdAddr 0 -> 4, rdAddr 15 -> 19 (wrap).
REQ-035 trigPc 5, POST_TRIG 4, arm, pc 0..12 stream -> trigger at 5, DONE after pc 9, count 10, rdAddr 9 -> 9, pc 10..12 not stored.
REQ-036 arm and trigForce same cycle with cpuEn -> state 1, count 0; later trigForce -> state 2.
REQ-037 With SM_TRACE_NOP_FILTER_EN, stream instr 0 at pc 3 and 4 -> count excludes them; trigPc 4 still triggers and stores pc 4.
